// File: rtl/multdiv_sequencer.sv
// Sequences the multi-cycle multiply/divide unit: start pulse, pipeline freeze while busy,
// then a one-cycle writeback presentation (result, or rstatus into r30 on exception).
module multdiv_sequencer #(
  parameter int TIMEOUT     = 40,
  parameter int CNT_W       = 6,
  parameter int RSTATUS_MUL = 4,
  parameter int RSTATUS_DIV = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       DX_opcode_wire,
  input  logic [4:0]       DX_ALU_op_wire,
  input  logic [4:0]       DX_rd_wire,
  input  logic             md_ready_in,
  input  logic             md_exception_in,
  input  logic [31:0]      md_result_in,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic             stall,
  output logic             md_valid,
  output logic [4:0]       md_wr_reg,
  output logic [31:0]      md_wr_data,
  output logic             md_exception,
  output logic [CNT_W-1:0] md_last_cycles
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [4:0] RSTATUS_REG = 5'd30;

  state_t             state_q, state_d;
  logic               mult_q, mult_d, div_q, div_d;
  logic               is_div_q, is_div_d;
  logic [4:0]         op_rd_q, op_rd_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               exc_q, exc_d;
  logic [4:0]         wr_reg_q, wr_reg_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic [CNT_W-1:0]   last_q, last_d;

  logic               md_req;
  logic               start_cycle;
  logic               fin;
  logic               fin_exc;
  logic [31:0]        fin_res;

  assign md_req = (DX_opcode_wire == 5'd0) &&
                  (DX_ALU_op_wire == 5'd6 || DX_ALU_op_wire == 5'd7);
  // The unit cannot be done in the cycle it is being started.
  assign start_cycle = mult_q | div_q;

  always_comb begin
    state_d   = state_q;
    mult_d    = 1'b0;
    div_d     = 1'b0;
    is_div_d  = is_div_q;
    op_rd_d   = op_rd_q;
    count_d   = count_q;
    exc_d     = exc_q;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    last_d    = last_q;
    stall     = 1'b0;
    md_valid  = 1'b0;
    fin       = 1'b0;
    fin_exc   = 1'b0;
    fin_res   = 32'd0;

    case (state_q)
      IDLE: begin
        stall = md_req;
        if (md_req) begin
          state_d  = BUSY;
          is_div_d = DX_ALU_op_wire[0];
          op_rd_d  = DX_rd_wire;
          count_d  = '0;
          mult_d   = ~DX_ALU_op_wire[0];
          div_d    = DX_ALU_op_wire[0];
        end
      end
      BUSY: begin
        stall   = 1'b1;
        count_d = count_q + CNT_W'(1);
        if (md_ready_in && !start_cycle) begin
          fin     = 1'b1;
          fin_exc = md_exception_in;
          fin_res = md_result_in;
        end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
          fin     = 1'b1;
          fin_exc = 1'b1;
          fin_res = 32'd0;
        end
        if (fin) begin
          state_d = DONE;
          exc_d   = fin_exc;
          last_d  = count_q + CNT_W'(1);
          if (fin_exc) begin
            wr_reg_d  = RSTATUS_REG;
            wr_data_d = is_div_q ? 32'(RSTATUS_DIV) : 32'(RSTATUS_MUL);
          end else begin
            wr_reg_d  = op_rd_q;
            wr_data_d = fin_res;
          end
        end
      end
      DONE: begin
        md_valid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mult_q    <= 1'b0;
      div_q     <= 1'b0;
      is_div_q  <= 1'b0;
      op_rd_q   <= 5'd0;
      count_q   <= '0;
      exc_q     <= 1'b0;
      wr_reg_q  <= 5'd0;
      wr_data_q <= 32'd0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      mult_q    <= mult_d;
      div_q     <= div_d;
      is_div_q  <= is_div_d;
      op_rd_q   <= op_rd_d;
      count_q   <= count_d;
      exc_q     <= exc_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      last_q    <= last_d;
    end
  end

  assign ctrl_MULT      = mult_q;
  assign ctrl_DIV       = div_q;
  assign md_exception   = exc_q;
  assign md_wr_reg      = wr_reg_q;
  assign md_wr_data     = wr_data_q;
  assign md_last_cycles = last_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: drives DX ops and unit handshakes at negedge,
// checks outputs 1ns later against hand-computed values.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  DX_opcode_wire = '0, DX_ALU_op_wire = '0, DX_rd_wire = '0;
  logic        md_ready_in = 1'b0, md_exception_in = 1'b0;
  logic [31:0] md_result_in = '0;
  logic        ctrl_MULT, ctrl_DIV, stall, md_valid, md_exception;
  logic [4:0]  md_wr_reg;
  logic [31:0] md_wr_data;
  logic [5:0]  md_last_cycles;

  int tests = 0;
  int fails = 0;

  multdiv_sequencer #(.TIMEOUT(40), .CNT_W(6), .RSTATUS_MUL(4), .RSTATUS_DIV(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .DX_opcode_wire(DX_opcode_wire), .DX_ALU_op_wire(DX_ALU_op_wire), .DX_rd_wire(DX_rd_wire),
    .md_ready_in(md_ready_in), .md_exception_in(md_exception_in), .md_result_in(md_result_in),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .stall(stall), .md_valid(md_valid),
    .md_wr_reg(md_wr_reg), .md_wr_data(md_wr_data), .md_exception(md_exception),
    .md_last_cycles(md_last_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_dx(input logic [4:0] opc, input logic [4:0] alu, input logic [4:0] rd);
    DX_opcode_wire = opc;
    DX_ALU_op_wire = alu;
    DX_rd_wire     = rd;
  endtask

  // Runs one MUL/DIV from its IDLE detect cycle (i=0) to DONE. md_ready_in pulses for one
  // cycle in BUSY cycle ready_at (1 = start-pulse cycle); 0 means never. Returns counts.
  task automatic run_op(input string tag, input logic [4:0] alu, input logic [4:0] rd,
                        input int ready_at, input logic exc, input logic [31:0] res,
                        output int n_stall, output int n_mult, output int n_div,
                        output int done_at);
    n_stall = 0; n_mult = 0; n_div = 0; done_at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      drive_dx(5'd0, alu, rd);
      md_ready_in     = (ready_at != 0) && (i == ready_at);
      md_result_in    = res;
      md_exception_in = exc;
      #1;
      if (md_valid) begin
        done_at = i;
        break;
      end
      if (stall)     n_stall++;
      if (ctrl_MULT) n_mult++;
      if (ctrl_DIV)  n_div++;
    end
    chk({tag, "_reached_done"}, 32'(done_at >= 0), 32'd1);
    chk({tag, "_done_stall"}, 32'(stall), 32'd0);
    chk({tag, "_done_pulses"}, 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    md_ready_in = 1'b0;
    drive_dx(5'd0, 5'd0, 5'd1);
  endtask

  int ns, nm, nd, da;

  initial begin
    // Reset state
    #1;
    chk("rst_valid", 32'(md_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wr_data", md_wr_data, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // MUL r5, result 42 in the 5th BUSY cycle
    run_op("mul", 5'd6, 5'd5, 5, 1'b0, 32'd42, ns, nm, nd, da);
    chk("mul_stall_cycles", 32'(ns), 32'd6);
    chk("mul_mult_pulses", 32'(nm), 32'd1);
    chk("mul_div_pulses", 32'(nd), 32'd0);
    chk("mul_done_at", 32'(da), 32'd6);
    chk("mul_wr_reg", 32'(md_wr_reg), 32'd5);
    chk("mul_wr_data", md_wr_data, 32'd42);
    chk("mul_exc", 32'(md_exception), 32'd0);
    chk("mul_last", 32'(md_last_cycles), 32'd5);

    // Outputs hold outside DONE, md_valid low
    @(negedge clock); #1;
    chk("hold_valid", 32'(md_valid), 32'd0);
    chk("hold_wr_data", md_wr_data, 32'd42);
    chk("hold_stall_add", 32'(stall), 32'd0);

    // DIV r7 with exception at ready
    run_op("div_exc", 5'd7, 5'd7, 3, 1'b1, 32'd99, ns, nm, nd, da);
    chk("div_exc_div_pulses", 32'(nd), 32'd1);
    chk("div_exc_mult_pulses", 32'(nm), 32'd0);
    chk("div_exc_wr_reg", 32'(md_wr_reg), 32'd30);
    chk("div_exc_wr_data", md_wr_data, 32'd5);
    chk("div_exc_exc", 32'(md_exception), 32'd1);
    chk("div_exc_last", 32'(md_last_cycles), 32'd3);

    // MUL r9, unit never ready -> timeout
    run_op("mul_to", 5'd6, 5'd9, 0, 1'b0, 32'd7, ns, nm, nd, da);
    chk("mul_to_done_at", 32'(da), 32'd41);
    chk("mul_to_stall_cycles", 32'(ns), 32'd41);
    chk("mul_to_wr_reg", 32'(md_wr_reg), 32'd30);
    chk("mul_to_wr_data", md_wr_data, 32'd4);
    chk("mul_to_exc", 32'(md_exception), 32'd1);
    chk("mul_to_last", 32'(md_last_cycles), 32'd40);

    // DIV r4 with ready only in the start-pulse cycle: must be ignored -> timeout
    run_op("div_early", 5'd7, 5'd4, 1, 1'b0, 32'd11, ns, nm, nd, da);
    chk("div_early_done_at", 32'(da), 32'd41);
    chk("div_early_wr_data", md_wr_data, 32'd5);
    chk("div_early_last", 32'(md_last_cycles), 32'd40);

    // Back-to-back MULs
    run_op("b2b_a", 5'd6, 5'd3, 2, 1'b0, 32'd100, ns, nm, nd, da);
    chk("b2b_a_pulses", 32'(nm), 32'd1);
    chk("b2b_a_wr_reg", 32'(md_wr_reg), 32'd3);
    chk("b2b_a_wr_data", md_wr_data, 32'd100);
    run_op("b2b_b", 5'd6, 5'd12, 2, 1'b0, 32'd200, ns, nm, nd, da);
    chk("b2b_b_pulses", 32'(nm), 32'd1);
    chk("b2b_b_done_at", 32'(da), 32'd3);
    chk("b2b_b_wr_reg", 32'(md_wr_reg), 32'd12);
    chk("b2b_b_wr_data", md_wr_data, 32'd200);
    chk("b2b_b_last", 32'(md_last_cycles), 32'd2);

    // Reset during the 3rd BUSY cycle, late ready afterwards with ADD in DX
    @(negedge clock);
    drive_dx(5'd0, 5'd6, 5'd8);
    repeat (3) @(negedge clock);
    #1;
    chk("rst_pre_stall", 32'(stall), 32'd1);
    reset_n = 1'b0;
    drive_dx(5'd0, 5'd0, 5'd2);
    #1;
    chk("rst_async_stall", 32'(stall), 32'd0);
    chk("rst_async_last", 32'(md_last_cycles), 32'd0);
    chk("rst_async_wr_reg", 32'(md_wr_reg), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    md_ready_in = 1'b1; md_result_in = 32'd77;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_late_valid", 32'(md_valid), 32'd0);
      chk("rst_late_stall", 32'(stall), 32'd0);
      chk("rst_late_data", md_wr_data, 32'd0);
      @(negedge clock);
      md_ready_in = 1'b0;
    end

    // ADD, then ADDI (opcode 5) carrying ALU-op bits 6 and 7
    for (int k = 0; k < 3; k++) begin
      if (k == 0) drive_dx(5'd0, 5'd0, 5'd6);
      else        drive_dx(5'd5, 5'(5 + k), 5'd6);
      for (int c = 0; c < 2; c++) begin
        #1;
        chk("nonmd_stall", 32'(stall), 32'd0);
        chk("nonmd_pulses", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
        chk("nonmd_valid", 32'(md_valid), 32'd0);
        @(negedge clock);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Sequences the multi-cycle multiply/divide unit for the 5-stage pipeline.
- Detects MUL/DIV in the DX stage and issues a one-cycle start pulse to the multdiv unit.
- Freezes PC/FD/DX and bubbles XM while the unit runs, then presents the writeback target and data (result, or rstatus on exception) to the XM latch for one cycle.
- Sits beside the pipeline control decoder and replaces its combinational mult/div asserts.

Parameters:
- TIMEOUT, 40, max BUSY cycles before the op is forced to complete with an exception
- CNT_W, 6, width of the busy-cycle counter; must satisfy 2^CNT_W > TIMEOUT
- RSTATUS_MUL, 4, rstatus value written on multiply exception
- RSTATUS_DIV, 5, rstatus value written on divide exception

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- DX_opcode_wire  in  5  opcode of the instruction in DX
- DX_ALU_op_wire  in  5  ALU op field of the DX instruction
- DX_rd_wire  in  5  destination register of the DX instruction
- md_ready_in  in  1  multdiv data_resultRDY
- md_exception_in  in  1  multdiv data_exception, valid with md_ready_in
- md_result_in  in  32  multdiv data_result, valid with md_ready_in
- ctrl_MULT  out  1  one-cycle start pulse, multiply
- ctrl_DIV  out  1  one-cycle start pulse, divide
- stall  out  1  freeze PC/FD/DX enables; insert nop into XM
- md_valid  out  1  one cycle: XM latch takes md_wr_reg/md_wr_data instead of ALU output
- md_wr_reg  out  5  writeback register (rd, or 30 on exception)
- md_wr_data  out  32  writeback data (result, or rstatus on exception)
- md_exception  out  1  the completed op raised an exception
- md_last_cycles  out  CNT_W  BUSY cycle count of the last completed op

Behaviour:
- Detect: md_req = (DX_opcode_wire == 0) & (DX_ALU_op_wire == 6 or 7); ALU op 6 is MUL, ALU op 7 is DIV.
- States and transitions:
  - IDLE -> BUSY when md_req.
  - BUSY -> DONE on md_ready_in, or when count == TIMEOUT-1.
  - DONE -> IDLE unconditionally.
- IDLE:
  - stall = md_req (combinational).
  - On md_req: latch is_div = ALU op bit0 and op_rd = DX_rd_wire; clear count.
- BUSY:
  - First BUSY cycle: exactly one of ctrl_MULT/ctrl_DIV = 1 (registered, per is_div); zero in all other cycles.
  - stall = 1; count increments every BUSY cycle.
- BUSY exit on md_ready_in (checked before timeout if both occur in the same cycle):
  - Register md_exception_in and md_result_in.
  - md_ready_in is ignored in the start-pulse cycle.
- BUSY exit on timeout: md_exception = 1, result = 0.
- On either BUSY exit: md_last_cycles = count+1.
- DONE:
  - stall = 0, md_valid = 1; the frozen MUL/DIV advances into XM this edge.
  - No exception: md_wr_reg = op_rd, md_wr_data = result.
  - Exception: md_wr_reg = 30, md_wr_data = RSTATUS_DIV or RSTATUS_MUL zero-extended to 32 bits.
  - op_rd == 0 with no exception: md_valid still 1, md_wr_reg = 0; the register file discards it.
- Back-to-back MUL/DIV: DONE->IDLE, then the next instruction is detected in IDLE. Min spacing: DONE + IDLE + BUSY.
- md_wr_reg, md_wr_data and md_exception hold their values outside DONE; md_valid gates them.
- Reset (any state, async):
  - State -> IDLE.
  - ctrl_MULT, ctrl_DIV, md_valid, md_exception, md_wr_reg, md_wr_data, md_last_cycles, count, is_div, op_rd all 0.
  - stall = 0 unless md_req is present in IDLE after release.
  - An op in flight is abandoned; a late md_ready_in is ignored in IDLE.
- Non-MUL/DIV instructions: stall = 0, no pulses, md_valid = 0.

Test Plan:
- MUL r5 (opcode 0, ALU op 6, rd 5), unit returns 42 after 5 BUSY cycles -> ctrl_MULT high 1 cycle, stall high 6 cycles, then md_valid=1, md_wr_reg=5, md_wr_data=42, md_last_cycles=5.
- DIV with md_exception_in=1 at ready -> DONE shows md_wr_reg=30, md_wr_data=5, md_exception=1; ctrl_DIV pulsed once, ctrl_MULT never.
- MUL, md_ready_in never asserted -> exit at count 39, md_wr_reg=30, md_wr_data=4, md_last_cycles=40.
- Two MULs back-to-back in DX -> two separate ctrl_MULT pulses, two md_valid cycles, the second op's rd latched correctly.
- reset_n low in the 3rd BUSY cycle, md_ready_in pulsed after release with DX holding ADD -> all outputs 0, stall=0, no md_valid.
- ADD (ALU op 0) and ADDI (opcode 5, ALU-op bits 6) in DX -> stall, ctrl_MULT and ctrl_DIV stay 0.
